exit_status_uart_reporter: RTL
==============================

// Module: exit_status_uart_reporter
// PURPOSE
//  Sits downstream of cgra_x_heep_top in the FPGA wrapper. Consumes exit_valid/exit_value
//  and reports the program exit code over a debug UART TX pin as ASCII "XXXXXXXX\r\n"
//  (8 uppercase hex digits, MSB nibble first). Latches pass/fail LEDs afterwards, so
//  board runs can be checked without JTAG.
// PARAMETERS
//  CLK_FREQ_HZ  15_000_000  frequency of clk_gen in Hz
//  BAUD_RATE    115_200     UART bit rate; BAUD_DIV = CLK_FREQ_HZ/BAUD_RATE (truncated)
//  (elaboration assertion: BAUD_DIV >= 2)
// PORTS
//  clk_gen       in   1   system clock (clock wizard output)
//  rst_n         in   1   reset, asynchronous, active-low
//  exit_valid_i  in   1   exit flag from SoC; treated as asynchronous (pad-level)
//  exit_value_i  in   32  exit code; stable while exit_valid_i is high
//  tx_o          out  1   UART TX, 8N1, idle high
//  busy_o        out  1   report in progress
//  pass_o        out  1   last completed report had exit_value == 0
//  fail_o        out  1   last completed report had exit_value != 0
//  overrun_o     out  1   sticky: rising edge of exit_valid seen while busy
// BEHAVIOUR
//  Reset values: tx_o=1, busy_o=0, pass_o=0, fail_o=0, overrun_o=0, FSM=IDLE, counters 0.
//  Input sync: exit_valid_i goes through 2-FF synchronizer, then a 3rd FF for edge detection;
//   rise = sync2 & ~sync3. Input first sampled high at edge E0 -> rise high between E1 and E2.
//  FSM states: IDLE, SEND, DONE.
//   IDLE: on rise at E2, capture exit_value_i into value_q, char_idx=0, bit_idx=0,
//         baud_cnt=0, pass_o=fail_o=0, busy_o=1, tx_o=0 (start bit of char 0)
//         -> SEND. tx_o therefore falls at E2.
//   SEND: each bit lasts exactly BAUD_DIV cycles (baud_cnt 0..BAUD_DIV-1, wraps to 0).
//         Frame: start(0), d0..d7 LSB first, stop(1) = 10 bits.
//         Char sequence idx 0..9: idx 0..7 = hex of value_q[31-4i -: 4]; idx 8 = 0x0D;
//         idx 9 = 0x0A. Hex map: 0-9 -> 0x30+n, A-F -> 0x37+n.
//         At end of each stop bit: if idx<9, idx++ and next start bit begins immediately
//         (no extra idle cycles); if idx==9 -> DONE.
//   DONE: one cycle; tx_o=1, busy_o=0; pass_o=(value_q==0), fail_o=~pass_o -> IDLE.
//  Total report length: 100*BAUD_DIV cycles from E2 until tx_o returns to idle high.
//  Rise while busy (SEND or DONE): ignored (value_q unchanged); overrun_o set, cleared only by rst_n.
//  exit_valid_i staying high: no retrigger; a new report needs a low->high transition.
//  Rise in the same cycle as DONE: ignored and sets overrun_o; it is never queued.
//  exit_valid_i deasserting mid-report: no effect; report completes with value_q.
//  rst_n asserted mid-report: all outputs return to reset values asynchronously; tx_o
//   goes high immediately (truncated frame); pass/fail cleared.
//  pass_o/fail_o hold until the next report starts (cleared at its E2).
// STRUCTURE
//  Package exit_reporter_pkg: state enum (IDLE/SEND/DONE), ASCII_CR=8'h0D, ASCII_LF=8'h0A,
//   NUM_CHARS=10, function hex_to_ascii(logic[3:0]) -> logic[7:0].
//  Sub-module uart_tx_byte: baud counter + 10-bit shift frame, ports start/data[7:0]/
//   ready/tx, parameter BAUD_DIV; top FSM sequences chars through it (back-to-back
//   start on the ready cycle, so no gap between frames).
//  Top: synchronizer, edge detect, capture reg, char mux, FSM, status flags.
// TESTING  (CLK_FREQ_HZ=1_000_000, BAUD_RATE=250_000 -> BAUD_DIV=4; UART monitor on tx_o)
//  1 exit_value_i=32'h0000_0000, pulse exit_valid_i -> "00000000\r\n" decoded, tx low at E2,
//    idle high after 400 cycles, then pass_o=1 fail_o=0.
//  2 exit_value_i=32'hDEAD_BEEF -> bytes 44 45 41 44 42 45 45 46 0D 0A, each bit 4 cycles,
//    fail_o=1, pass_o=0, busy_o high exactly 401 cycles (SEND + DONE).
//  3 second rise 100 cycles into report with value 32'h1 -> report still DEADBEEF, overrun_o=1,
//    no second report.
//  4 rst_n low at cycle 150 of report -> tx_o=1 and busy_o=0 same cycle; after release and
//    new rise with 32'h0000_00A5 -> "000000A5\r\n", overrun_o=0.
//  5 exit_valid_i held high 2000 cycles -> exactly one report; pass/fail unchanged by hold.
//  6 glitch: exit_valid_i high for one cycle between edges -> report starts or not, but never
//    a partial or malformed frame.

Source files
------------

// File: rtl/exit_reporter_pkg.sv
// ---------------------------------------------------------------------------
// exit_reporter_pkg
// Shared types and constants for the exit-status UART reporter.
//   state_e       : top-level sequencer states (IDLE / SEND / DONE)
//   ASCII_CR/LF   : line terminator bytes sent after the 8 hex digits
//   NUM_CHARS     : characters per report ("XXXXXXXX\r\n")
//   hex_to_ascii  : nibble -> uppercase ASCII hex digit
// ---------------------------------------------------------------------------
package exit_reporter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam int         NUM_CHARS = 10;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 transmitter for one byte: start(0), d0..d7 LSB first, stop(1); every
// bit lasts BAUD_DIV clocks. tx_o is registered and idles high.
//   clk_gen  in   clock
//   rst_n    in   async active-low reset
//   start_i  in   load data_i and begin a frame (accepted only when ready_o)
//   data_i   in   byte to send
//   ready_o  out  idle, or in the final cycle of the stop bit; starting a new
//                 frame in that cycle makes frames back-to-back
//   tx_o     out  serial line
// ---------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int BAUD_DIV = 4
) (
  input  logic       clk_gen,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int             CW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt_q;
  logic [3:0]    bit_idx_q;
  logic [8:0]    shift_q;   // remaining data bits plus stop bit
  logic          active_q;
  logic          tx_q;
  logic          last_s;

  assign last_s  = active_q && (baud_cnt_q == BAUD_LAST) && (bit_idx_q == 4'd9);
  assign ready_o = ~active_q | last_s;
  assign tx_o    = tx_q;

  // Frame shifter and baud counter; start bit is driven on the load edge.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_q <= '0;
      bit_idx_q  <= 4'd0;
      shift_q    <= 9'h1FF;
      active_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (start_i && ready_o) begin
      baud_cnt_q <= '0;
      bit_idx_q  <= 4'd0;
      shift_q    <= {1'b1, data_i};
      active_q   <= 1'b1;
      tx_q       <= 1'b0;
    end else if (active_q) begin
      if (baud_cnt_q == BAUD_LAST) begin
        baud_cnt_q <= '0;
        if (bit_idx_q == 4'd9) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_idx_q <= bit_idx_q + 4'd1;
          tx_q      <= shift_q[0];
          shift_q   <= {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_cnt_q <= baud_cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/exit_status_uart_reporter.sv
// ---------------------------------------------------------------------------
// exit_status_uart_reporter
// On a rising edge of the (asynchronous) exit flag, sends the 32-bit exit
// code as "XXXXXXXX\r\n" over UART, then latches pass/fail status LEDs.
//   clk_gen       in   clock
//   rst_n         in   async active-low reset
//   exit_valid_i  in   exit flag (synchronized internally)
//   exit_value_i  in   exit code, stable while exit_valid_i is high
//   tx_o          out  UART TX, 8N1, idle high
//   busy_o        out  report in progress (SEND and DONE)
//   pass_o        out  last completed report had value 0
//   fail_o        out  last completed report had non-zero value
//   overrun_o     out  sticky: exit flag rose while a report was in progress
// ---------------------------------------------------------------------------
module exit_status_uart_reporter
  import exit_reporter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 15_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        overrun_o
);

  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;

  if (BAUD_DIV < 2) begin : g_baud_div_check
    $error("exit_status_uart_reporter: BAUD_DIV must be >= 2");
  end

  state_e      state_q;
  logic [2:0]  sync_q;      // [1:0] synchronizer, [2] edge-detect history
  logic [31:0] value_q;
  logic [3:0]  char_idx_q;
  logic        busy_q;
  logic        pass_q;
  logic        fail_q;
  logic        overrun_q;

  logic        rise_s;
  logic        start_s;
  logic [7:0]  data_s;
  logic        tx_ready_s;
  logic [3:0]  next_idx_s;

  assign rise_s     = sync_q[1] & ~sync_q[2];
  assign next_idx_s = char_idx_q + 4'd1;

  // Character idx of the report for code v: 8 hex digits MSB first, CR, LF.
  function automatic logic [7:0] char_at(input logic [31:0] v, input logic [3:0] idx);
    logic [31:0] sh;
    sh = v << {idx[2:0], 2'b00};
    if (idx < 4'd8) begin
      return hex_to_ascii(sh[31:28]);
    end else if (idx == 4'd8) begin
      return ASCII_CR;
    end else begin
      return ASCII_LF;
    end
  endfunction

  // Byte-level start requests; char 0 comes straight from the input because
  // value_q is only captured on the same edge the first frame starts.
  always_comb begin
    start_s = 1'b0;
    data_s  = 8'h00;
    case (state_q)
      IDLE: begin
        start_s = rise_s;
        data_s  = hex_to_ascii(exit_value_i[31:28]);
      end
      SEND: begin
        start_s = tx_ready_s && (char_idx_q != 4'(NUM_CHARS - 1));
        data_s  = char_at(value_q, next_idx_s);
      end
      default: begin
        start_s = 1'b0;
        data_s  = 8'h00;
      end
    endcase
  end

  // Synchronizer, report sequencer and status flags.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 3'b000;
      state_q    <= IDLE;
      value_q    <= 32'h0;
      char_idx_q <= 4'd0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], exit_valid_i};
      case (state_q)
        IDLE: begin
          if (rise_s) begin
            value_q    <= exit_value_i;
            char_idx_q <= 4'd0;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (rise_s) begin
            overrun_q <= 1'b1;
          end
          if (tx_ready_s) begin
            if (char_idx_q == 4'(NUM_CHARS - 1)) begin
              state_q <= DONE;
            end else begin
              char_idx_q <= next_idx_s;
            end
          end
        end
        DONE: begin
          // A rise here is never queued.
          if (rise_s) begin
            overrun_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          pass_q  <= (value_q == 32'h0);
          fail_q  <= (value_q != 32'h0);
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk_gen (clk_gen),
    .rst_n   (rst_n),
    .start_i (start_s),
    .data_i  (data_s),
    .ready_o (tx_ready_s),
    .tx_o    (tx_o)
  );

  assign busy_o    = busy_q;
  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign overrun_o = overrun_q;

endmodule
